// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Constants and types shared by the data-memory stage and the
//               benches around it: default data-segment base, the memory
//               FSM state encoding and the load/store opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  // Byte address of data-memory word 0.
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  // Memory-controller FSM encoding.
  localparam int STATE_W = 1;
  typedef enum logic [STATE_W-1:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // RV32I major opcodes for loads and stores.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
// ============================================================================
// Module      : data_mem_ctrl_if
// Description : Core <-> data-memory bundle.
//               master : core side (drives strobes, address, store data)
//               slave  : memory side (returns load data, ready and errors)
//               MemRead/MemWrite  read/write strobes
//               dAddress          byte address
//               dWriteData        store data
//               dReadData         registered load data
//               mem_ready         clear sequence finished
//               err_misalign/err_range/err_conflict  sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        mem_ready;
  logic        err_misalign;
  logic        err_range;
  logic        err_conflict;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
    input  dReadData, mem_ready, err_misalign, err_range, err_conflict
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
    output dReadData, mem_ready, err_misalign, err_range, err_conflict
  );
endinterface

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous RAM, DEPTH x 32, registered read.
//               clk    clock
//               we     write enable (writes wdata to addr on posedge)
//               re     read enable  (captures mem[addr] on posedge)
//               addr   word index
//               wdata  write data
//               rdata  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ram #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic          re,
  input  wire logic [AW-1:0] addr,
  input  wire logic [31:0]   wdata,
  output logic      [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage has no reset; the controller clears it with a write sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module      : data_mem_ctrl
// Description : Data-memory stage behind the multicycle RISC-V core.
//               Zero-clears its RAM after every reset, then services single
//               aligned in-range reads/writes and flags bad accesses with
//               sticky error bits.
//               clk  clock, all state on posedge
//               rst  asynchronous active-low reset
//               bus  data_mem_ctrl_if.slave (strobes, address, data, flags)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
  parameter logic [31:0] DATA_BASE = riscv_pkg::DATA_BASE,
  parameter int          DEPTH     = 1024
) (
  input wire logic           clk,
  input wire logic           rst,
  data_mem_ctrl_if.slave     bus
);
  import riscv_pkg::*;

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] RANGE = 32'(4 * DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            err_mis_q, err_mis_d;
  logic            err_rng_q, err_rng_d;
  logic            err_cfl_q, err_cfl_d;
  // When set, dReadData is forced to zero (after reset or an invalid read);
  // otherwise it shows the RAM's registered read word.
  logic            zero_q, zero_d;

  logic [31:0]     off;
  logic            in_range, aligned, one_strobe, any_strobe;
  logic            valid;
  logic [AW-1:0]   word_idx;

  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata, ram_rdata;

  // ---------------- address decode ----------------
  assign off        = bus.dAddress - DATA_BASE;
  assign in_range   = (bus.dAddress >= DATA_BASE) && (off < RANGE);
  assign aligned    = (bus.dAddress[1:0] == 2'b00);
  assign word_idx   = off[AW+1:2];
  assign one_strobe = bus.MemRead ^ bus.MemWrite;
  assign any_strobe = bus.MemRead | bus.MemWrite;
  assign valid      = one_strobe && aligned && in_range;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs / RAM port mux ----------------
  always_comb begin
    bus.mem_ready = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = word_idx;
    ram_wdata     = bus.dWriteData;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_idx_q;
        ram_wdata = '0;
      end
      ST_READY: begin
        bus.mem_ready = 1'b1;
        ram_we        = valid && bus.MemWrite;
        ram_re        = valid && bus.MemRead;
      end
      default: ;
    endcase
  end

  // ---------------- error flags and read-data zeroing ----------------
  always_comb begin
    err_mis_d = err_mis_q;
    err_rng_d = err_rng_q;
    err_cfl_d = err_cfl_q;
    zero_d    = zero_q;
    if (state_q == ST_READY && any_strobe) begin
      if (!aligned)  err_mis_d = 1'b1;
      if (!in_range) err_rng_d = 1'b1;
      if (bus.MemRead && bus.MemWrite) err_cfl_d = 1'b1;
      // Any read strobe either loads a fresh word or returns zero.
      if (bus.MemRead) zero_d = !valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
      err_cfl_q <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
      err_cfl_q <= err_cfl_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.dReadData    = zero_q ? 32'h0 : ram_rdata;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_range    = err_rng_q;
  assign bus.err_conflict = err_cfl_q;

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed, table-driven bench for data_mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;
  import riscv_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] B     = 32'h1001_0000;
  localparam logic [31:0] ENDA  = B + 32'(4 * DEPTH);

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .DATA_BASE (B),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [2:0]  exp_err;   // {conflict, range, misalign}
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] errs();
    return {bus.err_conflict, bus.err_range, bus.err_misalign};
  endfunction

  // Called at a negedge: drive one access, let one posedge pass, return at
  // the following negedge with strobes dropped.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.dAddress   = a;
    bus.dWriteData = d;
    @(negedge clk);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // Called at a negedge right after reset release. Counts posedges until
  // mem_ready; hammers the port with junk accesses while clearing.
  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!bus.mem_ready && cnt < DEPTH + 8) begin
      if (cnt[0] == 1'b0) begin
        bus.MemRead = 1'b0; bus.MemWrite = 1'b1;
        bus.dAddress = B + 32'hC; bus.dWriteData = 32'hFFFF_FFFF;
      end else begin
        bus.MemRead = 1'b1; bus.MemWrite = 1'b1;
        bus.dAddress = 32'h1000_0001; bus.dWriteData = 32'h0;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    chk({name, " clear cycles"}, 32'(cnt), 32'(DEPTH));
    chk({name, " rdata after clear"}, bus.dReadData, 32'h0);
    chk({name, " errs after clear"}, 32'(errs()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nerr = 0;
    vecs[0]  = '{1'b0, 1'b1, B + 32'h08, 32'hDEADBEEF, 32'h0,        3'b000};
    vecs[1]  = '{1'b1, 1'b0, B + 32'h08, 32'h0,        32'hDEADBEEF, 3'b000};
    vecs[2]  = '{1'b0, 1'b0, B + 32'h08, 32'h0,        32'hDEADBEEF, 3'b000};
    vecs[3]  = '{1'b1, 1'b0, B + 32'h0C, 32'h0,        32'h0,        3'b000};
    vecs[4]  = '{1'b0, 1'b1, B,          32'h12345678, 32'h0,        3'b000};
    vecs[5]  = '{1'b1, 1'b0, B,          32'h0,        32'h12345678, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, B + 32'h02, 32'h0,        32'h0,        3'b001};
    vecs[7]  = '{1'b1, 1'b0, B,          32'h0,        32'h12345678, 3'b001};
    vecs[8]  = '{1'b0, 1'b1, B - 32'h4,  32'h11111111, 32'h12345678, 3'b011};
    vecs[9]  = '{1'b0, 1'b1, ENDA,       32'h22222222, 32'h12345678, 3'b011};
    vecs[10] = '{1'b1, 1'b0, ENDA,       32'h0,        32'h0,        3'b011};
    vecs[11] = '{1'b1, 1'b0, ENDA - 4,   32'h0,        32'h0,        3'b011};
    vecs[12] = '{1'b0, 1'b1, ENDA - 4,   32'hAAAA5555, 32'h0,        3'b011};
    vecs[13] = '{1'b1, 1'b0, ENDA - 4,   32'h0,        32'hAAAA5555, 3'b011};
    vecs[14] = '{1'b1, 1'b1, B + 32'h04, 32'h5,        32'h0,        3'b111};
    vecs[15] = '{1'b1, 1'b0, B + 32'h04, 32'h0,        32'h0,        3'b111};
    vecs[16] = '{1'b1, 1'b0, B,          32'h0,        32'h12345678, 3'b111};
    vecs[17] = '{1'b0, 1'b1, B + 32'h08, 32'hCAFEF00D, 32'h12345678, 3'b111};
    vecs[18] = '{1'b1, 1'b0, B + 32'h08, 32'h0,        32'hCAFEF00D, 3'b111};

    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.dAddress = '0; bus.dWriteData = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rdata", bus.dReadData, 32'h0);
    chk("reset ready", 32'(bus.mem_ready), 32'h0);
    chk("reset errs", 32'(errs()), 32'h0);

    rst = 1'b1;
    wait_ready("first");

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rdata", i), bus.dReadData, vecs[i].exp_rd);
      chk($sformatf("vec%0d errs", i), 32'(errs()), 32'(vecs[i].exp_err));
    end

    // Asynchronous reset after writes: outputs drop without a clock edge.
    #1 rst = 1'b0;
    #1;
    chk("async rst rdata", bus.dReadData, 32'h0);
    chk("async rst errs", 32'(errs()), 32'h0);
    chk("async rst ready", 32'(bus.mem_ready), 32'h0);

    // Reset again mid-clear; the sweep must restart from index 0.
    @(negedge clk);
    rst = 1'b1;
    repeat (DEPTH / 2) @(negedge clk);
    chk("mid-clear ready", 32'(bus.mem_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ready("rerun");

    drive(1'b1, 1'b0, B + 32'h08, 32'h0);
    chk("post-reset word2", bus.dReadData, 32'h0);
    drive(1'b1, 1'b0, B, 32'h0);
    chk("post-reset word0", bus.dReadData, 32'h0);

    // Error bits are independent: conflict alone, then range added.
    drive(1'b1, 1'b1, B + 32'h04, 32'h5);
    chk("conflict only errs", 32'(errs()), 32'h4);
    chk("conflict rdata", bus.dReadData, 32'h0);
    drive(1'b0, 1'b1, B - 32'h4, 32'h7);
    chk("range added errs", 32'(errs()), 32'h6);
    drive(1'b1, 1'b0, B + 32'h04, 32'h0);
    chk("conflict no write", bus.dReadData, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
